// File: rtl/ps_port_arbiter_pkg.sv
// Shared types and helpers for the MMCM phase-shift port arbiter.
package ps_port_arbiter_pkg;

  localparam int   PS_CNT_W   = 16;
  localparam logic PS_DIR_INC = 1'b1;
  localparam logic PS_DIR_DEC = 1'b0;

  typedef enum logic [4:0] {
    PS_IDLE  = 5'b00001,
    PS_PULSE = 5'b00010,
    PS_WAIT  = 5'b00100,
    PS_GAP   = 5'b01000,
    PS_DONE  = 5'b10000
  } ps_state_t;

  // One fine step with wrap-around by comparison, so no divider is needed.
  function automatic logic [15:0] ps_phase_step(input logic [15:0] pos, input logic dir,
                                                input logic [15:0] wrap_m1);
    logic [15:0] nxt;
    nxt = pos;
    case (dir)
      PS_DIR_INC: nxt = (pos == wrap_m1) ? 16'd0 : pos + 16'd1;
      PS_DIR_DEC: nxt = (pos == 16'd0) ? wrap_m1 : pos - 16'd1;
      default:    nxt = pos;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ps_port_arbiter_if.sv
// Requester handshake plus MMCM PSEN/PSINCDEC/PSDONE bundle.
interface ps_port_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_incdec;
  logic [16*NREQ-1:0]   req_steps;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic                 psen;
  logic                 psincdec;
  logic                 psdone;

  modport slave (
    input  req, req_incdec, req_steps, psdone,
    output gnt, ack, err, psen, psincdec
  );

  modport master (
    output req, req_incdec, req_steps, psdone,
    input  gnt, ack, err, psen, psincdec
  );
endinterface

// File: rtl/ps_port_arbiter_rr_select.sv
// Combinational round-robin pick: first unmasked request at or after ptr.
module ps_port_arbiter_rr_select #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   sel_idx,
  output logic            any
);
  logic [NREQ-1:0] req_eff;
  logic [IW-1:0]   idx_v;
  int              idx_t;

  assign req_eff = req & ~mask;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    idx_t   = 0;
    idx_v   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_t = int'(ptr) + k;
      if (idx_t >= NREQ) idx_t = idx_t - NREQ;
      idx_v = IW'(idx_t);
      if (!any && req_eff[idx_v]) begin
        sel[idx_v] = 1'b1;
        sel_idx    = idx_v;
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps_port_arbiter.sv
// Round-robin owner of the MMCM dynamic phase-shift port; runs N fine steps per
// grant, tracks absolute phase modulo one output period, aborts on missing psdone.
module ps_port_arbiter
  import ps_port_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int PHASE_WRAP = 560,
  parameter int TIMEOUT    = 1024
) (
  input  logic             psclk,
  input  logic             reset,
  ps_port_arbiter_if.slave bus,
  output logic [15:0]      phase_pos,
  output logic             ps_busy,
  output logic             timeout_flag
);
  localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] WRAP_M1 = 16'(PHASE_WRAP - 1);

  ps_state_t            state;
  logic [NREQ-1:0]      gnt_q, ack_q, err_q, mask_q, sel;
  logic [IW-1:0]        ptr_q, sel_idx;
  logic                 any_req, sel_dir, dir_q, psen_q, abort_q, busy_q, tflag_q;
  logic [PS_CNT_W-1:0]  steps_q, cnt_q, sel_steps;
  logic [WD_W-1:0]      wd_q;
  logic [15:0]          phase_q;

  ps_port_arbiter_rr_select #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (bus.req),
    .mask    (mask_q),
    .ptr     (ptr_q),
    .sel     (sel),
    .sel_idx (sel_idx),
    .any     (any_req)
  );

  always_comb begin
    sel_dir   = 1'b0;
    sel_steps = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_dir   = bus.req_incdec[i];
        sel_steps = bus.req_steps[PS_CNT_W*i +: PS_CNT_W];
      end
    end
  end

  // psen is raised on the edge entering PULSE so it is high for exactly that state.
  always_ff @(posedge psclk) begin
    if (reset) begin
      state   <= PS_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      psen_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      tflag_q <= 1'b0;
      steps_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      phase_q <= '0;
    end else begin
      ack_q  <= '0;
      err_q  <= '0;
      psen_q <= 1'b0;
      case (state)
        PS_IDLE: begin
          mask_q <= '0;
          if (any_req) begin
            gnt_q   <= sel;
            ptr_q   <= (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
            dir_q   <= sel_dir;
            steps_q <= sel_steps;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            if (sel_steps == '0) begin
              state <= PS_DONE;
            end else begin
              psen_q <= 1'b1;
              state  <= PS_PULSE;
            end
          end else begin
            gnt_q <= '0;
          end
        end
        PS_PULSE: begin
          wd_q  <= '0;
          state <= PS_WAIT;
        end
        PS_WAIT: begin
          if (bus.psdone) begin
            cnt_q   <= cnt_q + PS_CNT_W'(1);
            phase_q <= ps_phase_step(phase_q, dir_q, WRAP_M1);
            state   <= (cnt_q + PS_CNT_W'(1) == steps_q) ? PS_DONE : PS_GAP;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            abort_q <= 1'b1;
            tflag_q <= 1'b1;
            state   <= PS_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        PS_GAP: begin
          psen_q <= 1'b1;
          state  <= PS_PULSE;
        end
        PS_DONE: begin
          ack_q  <= gnt_q;
          err_q  <= abort_q ? gnt_q : '0;
          mask_q <= gnt_q;
          busy_q <= 1'b0;
          state  <= PS_IDLE;
        end
        default: state <= PS_IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.psen     = psen_q;
  assign bus.psincdec = dir_q;
  assign phase_pos    = phase_q;
  assign ps_busy      = busy_q;
  assign timeout_flag = tflag_q;
endmodule

// File: tb/tb_ps_port_arbiter.sv
// Directed bench for ps_port_arbiter with a simple MMCM psdone responder.
module tb_ps_port_arbiter;
  localparam int NREQ       = 2;
  localparam int PHASE_WRAP = 560;
  localparam int TIMEOUT    = 16;

  logic        psclk = 1'b0;
  logic        reset;
  logic [15:0] phase_pos;
  logic        ps_busy;
  logic        timeout_flag;

  int tests_run    = 0;
  int tests_failed = 0;

  logic mmcm_en    = 1'b0;
  int   done_delay = 12;

  int cyc            = 0;
  int last_psen_cyc  = -100;
  int psen_cnt       = 0;
  int short_gap_cnt  = 0;
  int psen_nognt_cnt = 0;
  int gnt1_cnt       = 0;
  int multihot_cnt   = 0;

  ps_port_arbiter_if #(.NREQ(NREQ)) bus ();

  ps_port_arbiter #(
    .NREQ       (NREQ),
    .PHASE_WRAP (PHASE_WRAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .psclk        (psclk),
    .reset        (reset),
    .bus          (bus),
    .phase_pos    (phase_pos),
    .ps_busy      (ps_busy),
    .timeout_flag (timeout_flag)
  );

  always #5 psclk = ~psclk;

  always @(posedge psclk) cyc <= cyc + 1;

  // Passive monitors sampled mid-cycle.
  always @(negedge psclk) begin
    if (bus.psen) begin
      psen_cnt <= psen_cnt + 1;
      if (cyc - last_psen_cyc < 2) short_gap_cnt <= short_gap_cnt + 1;
      last_psen_cyc <= cyc;
      if (bus.gnt == '0) psen_nognt_cnt <= psen_nognt_cnt + 1;
    end
    if (bus.gnt[1]) gnt1_cnt <= gnt1_cnt + 1;
    if ($countones(bus.gnt) > 1) multihot_cnt <= multihot_cnt + 1;
  end

  // MMCM model: one psdone pulse done_delay cycles after each observed psen.
  initial begin
    bus.psdone = 1'b0;
    forever begin
      @(negedge psclk);
      if (mmcm_en && bus.psen === 1'b1) begin
        repeat (done_delay) @(posedge psclk);
        #1 bus.psdone = 1'b1;
        @(posedge psclk);
        #1 bus.psdone = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation did not complete");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] which, input logic [NREQ-1:0] dir,
                               input logic [15:0] steps);
    @(negedge psclk);
    for (int i = 0; i < NREQ; i++) begin
      if (which[i]) begin
        bus.req[i]               = 1'b1;
        bus.req_incdec[i]        = dir[i];
        bus.req_steps[16*i +: 16] = steps;
      end
    end
    @(posedge psclk);
  endtask

  task automatic waitAck(input int budget, output logic [NREQ-1:0] ackv,
                         output logic [NREQ-1:0] errv, output int lat);
    ackv = '0;
    errv = '0;
    lat  = 0;
    while (ackv == '0 && lat < budget) begin
      @(negedge psclk);
      lat++;
      ackv = bus.ack;
      errv = bus.err;
    end
  endtask

  task automatic doReset();
    @(negedge psclk);
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge psclk);
    @(negedge psclk);
    reset = 1'b0;
  endtask

  logic [NREQ-1:0] ackv, errv;
  int lat, psen0, gnt10, gap0, nognt0, multi0;

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_incdec = '0;
    bus.req_steps  = '0;
    repeat (3) @(posedge psclk);
    @(negedge psclk);
    checkOutput("rst_gnt", bus.gnt, 0);
    checkOutput("rst_ack", bus.ack, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_psen", bus.psen, 0);
    checkOutput("rst_psincdec", bus.psincdec, 0);
    checkOutput("rst_phase", phase_pos, 0);
    checkOutput("rst_busy", ps_busy, 0);
    checkOutput("rst_tflag", timeout_flag, 0);
    reset = 1'b0;

    // Test 1: three increment steps with a slow psdone.
    mmcm_en = 1'b1; done_delay = 12;
    psen0 = psen_cnt; gnt10 = gnt1_cnt; gap0 = short_gap_cnt;
    applyStimulus(2'b01, 2'b01, 16'd3);
    @(negedge psclk);
    checkOutput("t1_gnt_next", bus.gnt, 2'b01);
    checkOutput("t1_psen_next", bus.psen, 1);
    checkOutput("t1_psincdec", bus.psincdec, 1);
    checkOutput("t1_busy", ps_busy, 1);
    waitAck(200, ackv, errv, lat);
    checkOutput("t1_ack", ackv, 2'b01);
    checkOutput("t1_err", errv, 0);
    checkOutput("t1_gnt_at_ack", bus.gnt, 2'b01);
    bus.req[0] = 1'b0;
    checkOutput("t1_psen_count", psen_cnt - psen0, 3);
    checkOutput("t1_phase", phase_pos, 3);
    @(negedge psclk);
    checkOutput("t1_ack_once", bus.ack, 0);
    checkOutput("t1_gnt_drop", bus.gnt, 0);
    checkOutput("t1_gnt1_never", gnt1_cnt - gnt10, 0);
    checkOutput("t1_psen_spacing", short_gap_cnt - gap0, 0);

    // Test 2: round-robin between two simultaneous requesters.
    doReset();
    done_delay = 4;
    psen0 = psen_cnt; nognt0 = psen_nognt_cnt; multi0 = multihot_cnt;
    applyStimulus(2'b11, 2'b11, 16'd1);
    @(negedge psclk);
    checkOutput("t2_first_gnt", bus.gnt, 2'b01);
    gnt10 = gnt1_cnt;
    waitAck(200, ackv, errv, lat);
    checkOutput("t2_ack_a", ackv, 2'b01);
    checkOutput("t2_gnt1_before_ack0", gnt1_cnt - gnt10, 0);
    bus.req[0] = 1'b0;
    waitAck(200, ackv, errv, lat);
    checkOutput("t2_ack_b", ackv, 2'b10);
    bus.req[1] = 1'b0;
    applyStimulus(2'b11, 2'b11, 16'd1);
    waitAck(200, ackv, errv, lat);
    checkOutput("t2_ack_c_wrap", ackv, 2'b01);
    bus.req[0] = 1'b0;
    waitAck(200, ackv, errv, lat);
    checkOutput("t2_ack_d", ackv, 2'b10);
    bus.req[1] = 1'b0;
    checkOutput("t2_psen_count", psen_cnt - psen0, 4);
    checkOutput("t2_phase", phase_pos, 4);
    checkOutput("t2_psen_outside_gnt", psen_nognt_cnt - nognt0, 0);
    checkOutput("t2_gnt_onehot", multihot_cnt - multi0, 0);

    // Test 3a: decrement wraps below zero.
    doReset();
    applyStimulus(2'b10, 2'b00, 16'd2);
    waitAck(200, ackv, errv, lat);
    checkOutput("t3_dec_ack", ackv, 2'b10);
    checkOutput("t3_dec_phase", phase_pos, 558);
    bus.req[1] = 1'b0;

    // Test 4: zero-step request completes without touching the MMCM.
    psen0 = psen_cnt;
    applyStimulus(2'b01, 2'b01, 16'd0);
    @(negedge psclk);
    checkOutput("t4_gnt", bus.gnt, 2'b01);
    checkOutput("t4_no_ack_yet", bus.ack, 0);
    @(negedge psclk);
    checkOutput("t4_ack", bus.ack, 2'b01);
    bus.req[0] = 1'b0;
    @(negedge psclk);
    checkOutput("t4_gnt_drop", bus.gnt, 0);
    checkOutput("t4_no_psen", psen_cnt - psen0, 0);
    checkOutput("t4_phase", phase_pos, 558);

    // Test 3b: increment wraps back to zero.
    applyStimulus(2'b10, 2'b10, 16'd2);
    waitAck(200, ackv, errv, lat);
    checkOutput("t3_inc_ack", ackv, 2'b10);
    checkOutput("t3_inc_phase", phase_pos, 0);
    bus.req[1] = 1'b0;

    // Test 5: psdone never arrives. Ack lands after PULSE, 16 WAIT cycles and DONE.
    mmcm_en = 1'b0;
    checkOutput("t5_tflag_before", timeout_flag, 0);
    psen0 = psen_cnt;
    applyStimulus(2'b01, 2'b01, 16'd4);
    @(negedge psclk);
    checkOutput("t5_psen", bus.psen, 1);
    waitAck(200, ackv, errv, lat);
    checkOutput("t5_ack", ackv, 2'b01);
    checkOutput("t5_err", errv, 2'b01);
    checkOutput("t5_latency", lat, 18);
    checkOutput("t5_tflag", timeout_flag, 1);
    checkOutput("t5_psen_count", psen_cnt - psen0, 1);
    checkOutput("t5_phase", phase_pos, 0);
    bus.req[0] = 1'b0;
    repeat (3) @(negedge psclk);
    checkOutput("t5_tflag_sticky", timeout_flag, 1);
    checkOutput("t5_busy_idle", ps_busy, 0);

    // Test 6: reset during the second step's WAIT.
    mmcm_en = 1'b1; done_delay = 12;
    psen0 = psen_cnt;
    applyStimulus(2'b01, 2'b01, 16'd4);
    repeat (20) @(negedge psclk);
    checkOutput("t6_psen_before_rst", psen_cnt - psen0, 2);
    checkOutput("t6_phase_before_rst", phase_pos, 1);
    checkOutput("t6_busy_before_rst", ps_busy, 1);
    reset   = 1'b1;
    bus.req = '0;
    @(negedge psclk);
    checkOutput("t6_rst_gnt", bus.gnt, 0);
    checkOutput("t6_rst_psen", bus.psen, 0);
    checkOutput("t6_rst_phase", phase_pos, 0);
    checkOutput("t6_rst_busy", ps_busy, 0);
    checkOutput("t6_rst_tflag", timeout_flag, 0);
    reset = 1'b0;
    repeat (10) @(negedge psclk);
    checkOutput("t6_late_psdone_phase", phase_pos, 0);
    checkOutput("t6_late_psdone_busy", ps_busy, 0);
    applyStimulus(2'b01, 2'b01, 16'd1);
    waitAck(200, ackv, errv, lat);
    checkOutput("t6_new_ack", ackv, 2'b01);
    checkOutput("t6_new_err", errv, 0);
    checkOutput("t6_new_phase", phase_pos, 1);
    bus.req[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
